// File: rtl/hp_drain_sequencer.sv
// ---------------------------------------------------------------------------
// hp_drain_sequencer: arbitrates the four host-to-parasite register FIFOs and
// pops one byte at a time onto a valid/ready stream.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hp_drain_sequencer #(
  parameter int SETTLE_CYCLES = 2,
  parameter bit R3_PRIORITY   = 1'b1
) (
  input  logic       p_phi2,
  input  logic       p_rst,
  input  logic [3:0] p_chan_en,
  input  logic [3:0] p_data_available,
  input  logic       p_r3_two_bytes_available,
  input  logic       one_byte_mode,
  input  logic [7:0] p_data,
  output logic [3:0] p_selectData,
  output logic       p_rdstb_b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [1:0] out_chan,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_OFFER  = 3'd3,
    ST_SETTLE = 3'd4
  } state_t;

  localparam logic [3:0] c_settle_load = 4'(SETTLE_CYCLES);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_sel, w_sel_nxt;
  logic [1:0] r_grant, w_grant_nxt;
  logic [1:0] r_last, w_last_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_burst, w_burst_nxt;
  logic       r_valid, w_valid_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic [1:0] r_chan, w_chan_nxt;

  logic [3:0] w_elig;
  logic       w_hit;
  logic [1:0] w_pick;
  logic [1:0] w_idx;

  // R3 in two-byte mode is only worth draining once both bytes are present.
  always_comb begin
    w_elig = p_chan_en & p_data_available;
    if (!one_byte_mode && !p_r3_two_bytes_available) begin
      w_elig[2] = 1'b0;
    end
  end

  always_comb begin
    w_hit  = 1'b0;
    w_pick = r_last;
    w_idx  = r_last;
    if (R3_PRIORITY && w_elig[2]) begin
      w_hit  = 1'b1;
      w_pick = 2'd2;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        w_idx = r_last + 2'(k);
        if (!w_hit && w_elig[w_idx] && !(R3_PRIORITY && (w_idx == 2'd2))) begin
          w_hit  = 1'b1;
          w_pick = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_burst_nxt = r_burst;
    w_valid_nxt = r_valid;
    w_data_nxt  = r_data;
    w_chan_nxt  = r_chan;
    case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_sel_nxt   = 4'b0001 << w_pick;
          w_grant_nxt = w_pick;
          w_last_nxt  = w_pick;
          w_burst_nxt = (w_pick == 2'd2) && !one_byte_mode;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: w_state_nxt = ST_STROBE;
      ST_STROBE: begin
        w_data_nxt  = p_data;
        w_chan_nxt  = r_grant;
        w_valid_nxt = 1'b1;
        w_sel_nxt   = 4'b0000;
        w_state_nxt = ST_OFFER;
      end
      ST_OFFER: begin
        if (r_valid && out_ready) begin
          w_valid_nxt = 1'b0;
          if (r_burst) begin
            // Second R3 byte follows directly, without re-arbitration.
            w_burst_nxt = 1'b0;
            w_sel_nxt   = 4'b0001 << r_grant;
            w_state_nxt = ST_SETUP;
          end else begin
            w_cnt_nxt   = c_settle_load;
            w_state_nxt = ST_SETTLE;
          end
        end
      end
      ST_SETTLE: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge p_phi2) begin
    if (p_rst) begin
      r_state <= ST_IDLE;
      r_sel   <= 4'b0000;
      r_grant <= 2'd0;
      r_last  <= 2'd3;
      r_cnt   <= 4'd0;
      r_burst <= 1'b0;
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_chan  <= 2'd0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_burst <= w_burst_nxt;
      r_valid <= w_valid_nxt;
      r_data  <= w_data_nxt;
      r_chan  <= w_chan_nxt;
    end
  end

  assign p_selectData = r_sel;
  assign p_rdstb_b    = (r_state != ST_STROBE);
  assign out_valid    = r_valid;
  assign out_data     = r_data;
  assign out_chan     = r_chan;
  assign busy         = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_hp_drain_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hp_drain_sequencer: FIFO model plus scoreboard bench for the drain
// sequencer.   Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hp_drain_sequencer;

  localparam int SETTLE = 2;

  logic       clk = 1'b0;
  logic       p_rst;
  logic [3:0] p_chan_en;
  logic [3:0] p_data_available;
  logic       p_r3_two_bytes_available;
  logic       one_byte_mode;
  logic [7:0] p_data;
  logic       out_ready;
  logic [3:0] sel;
  logic       rdstb_b;
  logic       out_valid;
  logic [7:0] out_data;
  logic [1:0] out_chan;
  logic       busy;
  logic [3:0] rr_sel;
  logic       rr_rdstb_b, rr_valid, rr_busy;
  logic [7:0] rr_data;
  logic [1:0] rr_chan;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] mem [4][8];
  int         head [4] = '{0, 0, 0, 0};
  int         tail [4] = '{0, 0, 0, 0};
  logic       two_en;
  logic       rd_pend = 1'b0;
  int         cyc = 0;
  int         nstrobe = 0;
  int         strobe_cyc [$];
  logic [9:0] exp_q [$];
  int         base;

  hp_drain_sequencer #(.SETTLE_CYCLES(SETTLE), .R3_PRIORITY(1'b1)) dut (
    .p_phi2(clk), .p_rst(p_rst), .p_chan_en(p_chan_en),
    .p_data_available(p_data_available),
    .p_r3_two_bytes_available(p_r3_two_bytes_available),
    .one_byte_mode(one_byte_mode), .p_data(p_data),
    .p_selectData(sel), .p_rdstb_b(rdstb_b), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_chan(out_chan),
    .busy(busy)
  );

  hp_drain_sequencer #(.SETTLE_CYCLES(SETTLE), .R3_PRIORITY(1'b0)) dut_rr (
    .p_phi2(clk), .p_rst(p_rst), .p_chan_en(p_chan_en),
    .p_data_available(p_data_available),
    .p_r3_two_bytes_available(p_r3_two_bytes_available),
    .one_byte_mode(one_byte_mode), .p_data(p_data),
    .p_selectData(rr_sel), .p_rdstb_b(rr_rdstb_b), .out_valid(rr_valid),
    .out_ready(out_ready), .out_data(rr_data), .out_chan(rr_chan),
    .busy(rr_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // FIFO model: flags and muxed read data follow the queue state.
  always_comb begin
    p_data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      p_data_available[i] = (tail[i] != head[i]);
      if (sel[i] && (tail[i] != head[i])) p_data = mem[i][head[i] % 8];
    end
    p_r3_two_bytes_available = two_en && ((tail[2] - head[2]) >= 2);
  end

  always @(negedge clk) begin
    rd_pend <= !p_rst && !rdstb_b;
    if (!p_rst && !rdstb_b) begin
      check("strobe_onehot", 32'($onehot(sel)), 1);
      check("strobe_no_valid", out_valid, 0);
      nstrobe <= nstrobe + 1;
      strobe_cyc.push_back(cyc);
    end
  end

  // The popped byte leaves the FIFO once the strobe cycle has been sampled.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rd_pend) begin
      for (int i = 0; i < 4; i++) if (sel[i]) head[i] <= head[i] + 1;
    end
  end

  always @(negedge clk) begin
    if (!p_rst && out_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_depth", exp_q.size(), 1);
      end else begin
        check("beat", {out_chan, out_data}, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int ch, input logic [7:0] b);
    mem[ch][tail[ch] % 8] = b;
    tail[ch]++;
    exp_q.push_back({ch[1:0], b});
  endtask

  task automatic check_rst_outputs(input string tag);
    check({tag, "_sel"}, sel, 0);
    check({tag, "_rdstb"}, rdstb_b, 1);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_data"}, out_data, 0);
    check({tag, "_chan"}, out_chan, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic do_reset();
    p_rst = 1'b1;
    tick();
    tick();
    check_rst_outputs("rst");
    p_rst = 1'b0;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_q.size() == 0 && !busy) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    check("drain_done", 32'(done), 1);
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      tick();
    end
    check("wait_valid", out_valid, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    p_rst = 1'b1;
    p_chan_en = 4'hF;
    one_byte_mode = 1'b1;
    two_en = 1'b0;
    out_ready = 1'b1;
    do_reset();

    // Single R1 byte: latency and settle window.
    load(0, 8'h5A);
    tick(); check("t1_sel", sel, 4'b0001); check("t1_rdstb_hi", rdstb_b, 1);
    tick(); check("t1_rdstb_lo", rdstb_b, 0);
    tick(); check("t1_valid", out_valid, 1); check("t1_chan", out_chan, 0);
    check("t1_data", out_data, 8'h5A);
    load(0, 8'h6B);
    tick(); check("t1_settle0", sel, 0);
    tick(); check("t1_settle1", sel, 0);
    tick(); check("t1_settle2", sel, 0);
    tick(); check("t1_regrant", sel, 4'b0001);
    wait_drain();

    // Round robin across R1, R2, R4.
    do_reset();
    base = nstrobe;
    load(0, 8'hA0); load(1, 8'hB0); load(3, 8'hD0);
    load(0, 8'hA1); load(1, 8'hB1); load(3, 8'hD1);
    wait_drain();
    check("t2_strobes", nstrobe - base, 6);
    for (int i = 0; i < 5; i++)
      check("t2_gap", strobe_cyc[base + i + 1] - strobe_cyc[base + i], 4 + SETTLE);

    // R3 two-byte burst.
    one_byte_mode = 1'b0;
    load(2, 8'h12); load(2, 8'h34);
    repeat (6) tick();
    check("t3_no_grant", busy, 0);
    base = nstrobe;
    two_en = 1'b1;
    wait_drain();
    check("t3_strobes", nstrobe - base, 2);
    check("t3_gap", strobe_cyc[base + 1] - strobe_cyc[base], 3);

    // Backpressure.
    one_byte_mode = 1'b1;
    out_ready = 1'b0;
    load(0, 8'h77);
    wait_valid();
    base = nstrobe;
    repeat (5) begin
      tick();
      check("t4_hold_valid", out_valid, 1);
    end
    check("t4_no_strobe", nstrobe - base, 0);
    out_ready = 1'b1;
    tick();
    check("t4_valid_drop", out_valid, 0);
    check("t4_sb_empty", exp_q.size(), 0);
    wait_drain();

    // R1 and R3 together: fixed priority versus round robin.
    do_reset();
    load(2, 8'h03); load(0, 8'h01);
    tick();
    check("t5_r3_first", sel, 4'b0100);
    check("t5_rr_r1_first", rr_sel, 4'b0001);
    wait_drain();

    // Reset while the first R3 burst byte waits in OFFER.
    do_reset();
    one_byte_mode = 1'b0;
    two_en = 1'b1;
    out_ready = 1'b0;
    load(2, 8'hAB); load(2, 8'hCD);
    wait_valid();
    check("t6_first_chan", out_chan, 2);
    p_rst = 1'b1;
    tick();
    check_rst_outputs("t6_rst");
    exp_q.delete();
    base = nstrobe;
    p_rst = 1'b0;
    out_ready = 1'b1;
    load(0, 8'h99);
    wait_drain();
    check("t6_r3_left", tail[2] - head[2], 1);
    check("t6_one_strobe", nstrobe - base, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hp_drain_sequencer.md
Name: hp_drain_sequencer

Overview:
- Parasite-side controller for the four host-to-parasite register FIFOs (R1-R4).
- Watches the per-register data-available flags and arbitrates between them.
- Drives the parasite select and read-strobe signals to pop one byte at a time.
- Presents each popped byte, tagged with its register number, on a valid/ready stream to the parasite consumer (CPU shim or DMA engine).

Parameters:
- SETTLE_CYCLES, 2: idle cycles after a completed pop before any flag is re-sampled; covers the flag-deassert lag of the FIFOs. Legal range 1-15.
- R3_PRIORITY, 1: 1 = R3 has fixed highest priority; 0 = R3 joins the round robin.

Ports:
- p_phi2  in  1  parasite clock; all logic on the rising edge
- p_rst  in  1  synchronous reset, active-high
- p_chan_en  in  4  per-register drain enable; bit0 = R1 ... bit3 = R4
- p_data_available  in  4  FIFO non-empty flags, R1..R4
- p_r3_two_bytes_available  in  1  R3 holds two bytes
- one_byte_mode  in  1  R3 one-byte mode
- p_data  in  8  muxed FIFO read data
- p_selectData  out  4  one-hot register select
- p_rdstb_b  out  1  read strobe, active-low, one cycle per pop
- out_valid  out  1  byte available to consumer
- out_ready  in  1  consumer accepts byte
- out_data  out  8  popped byte
- out_chan  out  2  source register, 0 = R1 ... 3 = R4
- busy  out  1  high in any state other than IDLE

Behaviour:
- Single clock, p_phi2. Reset is synchronous and active-high on p_rst.
- Reset values:
  - state = IDLE
  - p_selectData = 0
  - p_rdstb_b = 1
  - out_valid = 0
  - out_data = 0x00, out_chan = 0
  - busy = 0
  - round-robin pointer last = 3 (so R1 wins first)
  - settle counter = 0, burst flag = 0
- Eligibility: elig[i] = p_chan_en[i] & p_data_available[i], with one exception. R3 with one_byte_mode = 0 additionally requires p_r3_two_bytes_available.
- Arbitration (IDLE only, one decision per cycle):
  - If R3_PRIORITY = 1 and elig[2], grant R3.
  - Otherwise grant the first eligible register after `last`, in cyclic order 0,1,2,3. R3 is excluded from this order when R3_PRIORITY = 1.
  - On grant, `last` := the granted register.
- States:
  - IDLE: on any eligible register, latch the grant and set p_selectData to the one-hot grant, then go to SETUP. Set burst = 1 iff the grant is R3 and one_byte_mode = 0. Otherwise stay in IDLE.
  - SETUP (1 cycle): select held, p_rdstb_b = 1. Next state is STROBE.
  - STROBE (1 cycle): p_rdstb_b = 0, select held. At the clock edge, capture out_data := p_data and out_chan := grant, set out_valid := 1, drive p_selectData := 0, p_rdstb_b := 1. Next state is OFFER.
  - OFFER: hold out_valid, out_data and out_chan stable until out_valid & out_ready.
    - On handshake with burst = 1: clear burst, re-assert the same select, go to SETUP. No re-arbitration and no settle between the two bytes.
    - On handshake with burst = 0: clear out_valid, load settle counter = SETTLE_CYCLES, go to SETTLE.
  - SETTLE: decrement each cycle; on 1, go to IDLE. Flags are ignored in this state.
- Latency:
  - Flag high in IDLE to strobe low is 2 cycles.
  - Flag to out_valid high is 3 cycles.
  - Minimum pop-to-pop period for single bytes is 4 + SETTLE_CYCLES cycles, with out_ready tied high.
- p_rdstb_b is low for exactly one cycle per byte and only while exactly one select bit is set. p_selectData is never multi-hot.
- Clearing p_chan_en or a flag dropping after grant does not abort the transaction. It affects only the next arbitration.
- one_byte_mode is sampled only at grant; a change mid-burst takes effect at the next grant.
- Reset mid-operation:
  - Immediate return to the reset values.
  - A byte already strobed but not yet accepted is discarded.
  - The second byte of a pending R3 burst is not read.
- No combinational path from any input to p_rdstb_b or p_selectData. out_valid does not depend combinationally on out_ready.

Test Plan:
- R1 flag high, enable = 0xF, out_ready = 1 -> p_selectData = 0001 at cycle 1, p_rdstb_b low at cycle 2, out_valid at cycle 3 with out_chan = 0 and out_data equal to the FIFO byte (e.g. 0x5A); flags ignored for 2 cycles afterwards.
- R1, R2 and R4 flags held high, R3_PRIORITY = 1 -> grant order R1, R2, R4, R1, ...; no register is granted twice in a row while the others are eligible.
- R3 two-byte mode: set R3 flag only -> no grant; then set two_bytes_available -> two strobes with no settle between them; out_chan = 2 on both bytes (e.g. 0x12 then 0x34); burst ends in SETTLE.
- Backpressure: out_ready low for 5 cycles in OFFER -> out_valid, out_data and out_chan stable throughout; no further strobe; single handshake on the cycle out_ready rises.
- R1 and R3 eligible simultaneously with R3_PRIORITY = 1 -> R3 granted first; with R3_PRIORITY = 0 and last = 3 -> R1 granted first.
- p_rst asserted during OFFER of an R3 first byte -> next cycle all outputs at reset values; second byte not strobed; after release, normal arbitration resumes with R1 winning.
